// File: rtl/ledout_pkg.sv
// Shared glyph set, segment decode and width helper for the 7-segment scan driver.
package ledout_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b0000001;
  localparam logic [6:0] SEG_B = 7'b0001110;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0010101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1100111;

  // Counter width for a modulus of n, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] s;
    s = SEG_0;
    case (nibble)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ledout_scan_timer.sv
// Scan timebase: slot prescaler, digit index, frame counter, blink phase and frame strobe.
module ledout_scan_timer
  import ledout_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter int unsigned IW           = idx_width(DIGITS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [IW-1:0] index,
  output logic          phase,
  output logic          frame_start
);

  localparam int unsigned PW = idx_width(SCAN_DIV);
  localparam int unsigned FW = idx_width(BLINK_FRAMES);

  logic [PW-1:0] presc;
  logic [FW-1:0] fcnt;

  // frame_start is high for the first cycle of each frame that follows an index wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= '0;
      index       <= '0;
      fcnt        <= '0;
      phase       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        if (index == IW'(DIGITS - 1)) begin
          index       <= '0;
          frame_start <= 1'b1;
          if (fcnt == FW'(BLINK_FRAMES - 1)) begin
            fcnt  <= '0;
            phase <= ~phase;
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end else begin
          index <= index + IW'(1);
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/ledout_scan.sv
// Time-multiplexed 7-segment driver with blanking, blink, leading-zero suppression and frame strobe.
module ledout_scan
  import ledout_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  en,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_suppress,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_tick
);

  localparam int unsigned IW = idx_width(DIGITS);

  logic [IW-1:0]     index;
  logic              phase;
  logic              frame_start;
  logic [3:0]        nib;
  logic              blank;
  logic              blink;
  logic              lz;
  logic              dark;
  logic [DIGITS-1:0] onehot;

  ledout_scan_timer #(
    .DIGITS       (DIGITS),
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES),
    .IW           (IW)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .index       (index),
    .phase       (phase),
    .frame_start (frame_start)
  );

  // Select the current slot's nibble and masks; lz holds when this and all higher nibbles are zero.
  always_comb begin
    nib    = 4'h0;
    blank  = 1'b0;
    blink  = 1'b0;
    lz     = 1'b0;
    onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (index == IW'(i)) begin
        nib       = value[4*i +: 4];
        blank     = blank_mask[i];
        blink     = blink_mask[i];
        onehot[i] = 1'b1;
        lz        = (i != 0);
        for (int j = 0; j < DIGITS; j++) begin
          if (j >= i && value[4*j +: 4] != 4'h0) lz = 1'b0;
        end
      end
    end
    dark = !en || blank || (blink && phase) || (lz_suppress && lz);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= '0;
      digit_sel  <= '0;
      frame_tick <= 1'b0;
    end else begin
      seg        <= dark ? 7'b0 : seg_decode(nib);
      digit_sel  <= dark ? '0 : onehot;
      frame_tick <= frame_start;
    end
  end

endmodule

// File: tb/tb_ledout_scan.sv
// Directed bench for ledout_scan: a 4-digit scanning instance and a 1-digit glyph instance.
module tb_ledout_scan;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] value;
  logic        en;
  logic [3:0]  blank_mask, blink_mask;
  logic        lz_suppress;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic        frame_tick;

  logic        rst1;
  logic [3:0]  value1;
  logic        en1;
  logic [0:0]  blank1, blink1;
  logic        lz1;
  logic [6:0]  seg1;
  logic [0:0]  sel1;
  logic        tick1;

  int vectors = 0;
  int errors  = 0;

  logic [6:0] glyph [16];

  ledout_scan #(.DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .value(value), .en(en), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .lz_suppress(lz_suppress), .seg(seg),
    .digit_sel(digit_sel), .frame_tick(frame_tick)
  );

  ledout_scan #(.DIGITS(1), .SCAN_DIV(2), .BLINK_FRAMES(1)) dut1 (
    .clk(clk), .rst(rst1), .value(value1), .en(en1), .blank_mask(blank1),
    .blink_mask(blink1), .lz_suppress(lz1), .seg(seg1),
    .digit_sel(sel1), .frame_tick(tick1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Expected {frame_tick, seg, digit_sel} for output cycle c (1 = first cycle after reset release).
  function automatic logic [11:0] expect4(int c, logic dk, logic tk);
    int d;
    logic [3:0] n;
    logic [3:0] sel;
    d   = ((c - 1) / 4) % 4;
    n   = value[4*d +: 4];
    sel = 4'b0001 << d;
    return dk ? {tk, 11'b0} : {tk, glyph[n], sel};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step();
    vectors++;
    if ({frame_tick, seg, digit_sel} !== 12'b0) begin
      errors++;
      $display("FAIL reset got=%b required=%b", {frame_tick, seg, digit_sel}, 12'b0);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [11:0] exp;
    do_reset();
    value = 16'h1234;
    for (int c = 1; c <= 20; c++) begin
      step();
      exp = expect4(c, 1'b0, c == 17);
      vectors++;
      if ({frame_tick, seg, digit_sel} !== exp) begin
        errors++;
        $display("FAIL scan c=%0d got=%b required=%b", c, {frame_tick, seg, digit_sel}, exp);
      end
    end
  endtask

  task automatic test_lz();
    logic [11:0] exp;
    int d;
    lz_suppress = 1'b1;
    value = 16'h0050;
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      step();
      d   = ((c - 1) / 4) % 4;
      exp = expect4(c, d >= 2, 1'b0);
      vectors++;
      if ({frame_tick, seg, digit_sel} !== exp) begin
        errors++;
        $display("FAIL lz_0050 c=%0d got=%b required=%b", c, {frame_tick, seg, digit_sel}, exp);
      end
    end
    value = 16'h0000;
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      step();
      d   = ((c - 1) / 4) % 4;
      exp = expect4(c, d != 0, 1'b0);
      vectors++;
      if ({frame_tick, seg, digit_sel} !== exp) begin
        errors++;
        $display("FAIL lz_0000 c=%0d got=%b required=%b", c, {frame_tick, seg, digit_sel}, exp);
      end
    end
    lz_suppress = 1'b0;
  endtask

  task automatic test_blink();
    logic [11:0] exp;
    int d, f;
    value = 16'h1234;
    blink_mask = 4'b0001;
    do_reset();
    for (int c = 1; c <= 64; c++) begin
      step();
      f   = (c - 1) / 16;
      d   = ((c - 1) / 4) % 4;
      exp = expect4(c, d == 0 && f >= 2, c > 1 && (c - 1) % 16 == 0);
      vectors++;
      if ({frame_tick, seg, digit_sel} !== exp) begin
        errors++;
        $display("FAIL blink c=%0d got=%b required=%b", c, {frame_tick, seg, digit_sel}, exp);
      end
    end
    blink_mask = 4'b0000;
  endtask

  task automatic test_enable();
    logic [11:0] exp;
    value = 16'h1234;
    do_reset();
    for (int c = 1; c <= 24; c++) begin
      en = !(c >= 11 && c <= 13);
      step();
      exp = expect4(c, !en, c == 17);
      vectors++;
      if ({frame_tick, seg, digit_sel} !== exp) begin
        errors++;
        $display("FAIL enable c=%0d got=%b required=%b", c, {frame_tick, seg, digit_sel}, exp);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [11:0] exp;
    value = 16'h1234;
    blink_mask = 4'b0001;
    do_reset();
    for (int c = 1; c <= 42; c++) step();
    rst = 1'b1;
    step();
    vectors++;
    if ({frame_tick, seg, digit_sel} !== 12'b0) begin
      errors++;
      $display("FAIL reset_mid got=%b required=%b", {frame_tick, seg, digit_sel}, 12'b0);
    end
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      exp = expect4(c, 1'b0, c == 17);
      vectors++;
      if ({frame_tick, seg, digit_sel} !== exp) begin
        errors++;
        $display("FAIL after_reset_mid c=%0d got=%b required=%b", c, {frame_tick, seg, digit_sel}, exp);
      end
    end
    blink_mask = 4'b0000;
  endtask

  task automatic test_glyph();
    logic [7:0] exp;
    rst1 = 1'b1;
    step();
    vectors++;
    if ({tick1, seg1, sel1} !== 9'b0) begin
      errors++;
      $display("FAIL reset1 got=%b required=%b", {tick1, seg1, sel1}, 9'b0);
    end
    rst1 = 1'b0;
    for (int n = 0; n < 16; n++) begin
      value1 = 4'(n);
      step();
      exp = {glyph[n], 1'b1};
      vectors++;
      if ({seg1, sel1} !== exp) begin
        errors++;
        $display("FAIL glyph n=%0h got=%b required=%b", n, {seg1, sel1}, exp);
      end
    end
  endtask

  initial begin
    glyph[0]  = 7'b1111110; glyph[1]  = 7'b0110000; glyph[2]  = 7'b1101101; glyph[3]  = 7'b1111001;
    glyph[4]  = 7'b0110011; glyph[5]  = 7'b1011011; glyph[6]  = 7'b1011111; glyph[7]  = 7'b1110000;
    glyph[8]  = 7'b1111111; glyph[9]  = 7'b1111011; glyph[10] = 7'b0000001; glyph[11] = 7'b0001110;
    glyph[12] = 7'b1001110; glyph[13] = 7'b0010101; glyph[14] = 7'b1001111; glyph[15] = 7'b1100111;

    rst = 1'b1; value = 16'h0; en = 1'b1; blank_mask = 4'b0; blink_mask = 4'b0; lz_suppress = 1'b0;
    rst1 = 1'b1; value1 = 4'h0; en1 = 1'b1; blank1 = 1'b0; blink1 = 1'b0; lz1 = 1'b0;

    test_reset();
    test_scan();
    test_lz();
    test_blink();
    test_enable();
    test_reset_mid();
    test_glyph();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
